stage_sequencer: RTL and testbench

Multicycle control FSM sitting directly upstream of netpath. It generates the one-hot stage strobes s_fe, s_dc, s_ex, s_me and s_wb that step netpath through fetch, decode, execute, memory and writeback. It stalls on memory wait, optionally skips the memory stage, halts on request, and keeps retired-instruction and stall-cycle counters.

---
 rtl/stage_pkg.sv | 38 +++
 rtl/stage_sequencer_sat_counter.sv | 27 ++
 rtl/stage_sequencer.sv | 97 +++++++++
 tb/tb_stage_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_pkg.sv
// ---------------------------------------------------------------------------
// stage_pkg
// Shared definitions for the multicycle stage sequencer and for netpath and its
// bench, which reuse the same state encodings.
//   STATE_W    : width of the encoded sequencer state
//   stage_t    : sequencer state enum (IDLE=0 .. HALT=6)
//   strobe_vec : maps a state to the one-hot strobe vector {fe,dc,ex,me,wb}
// ---------------------------------------------------------------------------
package stage_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_FE   = 3'd1,
    ST_DC   = 3'd2,
    ST_EX   = 3'd3,
    ST_ME   = 3'd4,
    ST_WB   = 3'd5,
    ST_HALT = 3'd6
  } stage_t;

  // IDLE and HALT map to all-zero, so at most one strobe is ever high.
  function automatic logic [4:0] strobe_vec(input stage_t st);
    logic [4:0] v;
    v = 5'b00000;
    case (st)
      ST_FE:   v = 5'b10000;
      ST_DC:   v = 5'b01000;
      ST_EX:   v = 5'b00100;
      ST_ME:   v = 5'b00010;
      ST_WB:   v = 5'b00001;
      default: v = 5'b00000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/stage_sequencer_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : count one event this cycle
//   count : current value, saturates at 2^W-1
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Increment only while below all-ones so the value holds at the ceiling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// ---------------------------------------------------------------------------
// stage_sequencer
// Multicycle control FSM that steps netpath through fetch, decode, execute,
// memory and writeback using one-hot stage strobes.
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   run         : level, permits instruction sequencing
//   mem_busy    : memory not ready, stalls FE and ME (ignored elsewhere)
//   is_mem_op   : current instruction is load/store, looked at only in EX
//   halt_req    : halt after the current instruction, looked at only in WB
//   s_fe..s_wb  : registered one-hot stage strobes
//   halted      : sequencer sits in HALT
//   instr_count : retired instructions, wraps modulo 2^CNT_W
//   stall_count : cycles stalled in FE/ME, saturates at 2^STALL_W-1
// ---------------------------------------------------------------------------
module stage_sequencer
  import stage_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int STALL_W = 16,
  parameter bit SKIP_ME = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               mem_busy,
  input  logic               is_mem_op,
  input  logic               halt_req,
  output logic               s_fe,
  output logic               s_dc,
  output logic               s_ex,
  output logic               s_me,
  output logic               s_wb,
  output logic               halted,
  output logic [CNT_W-1:0]   instr_count,
  output logic [STALL_W-1:0] stall_count
);

  stage_t state;
  stage_t next_state;
  logic   stall_inc;

  // Next-state rules. A run drop mid-instruction is only honoured in WB, so
  // the instruction in flight always completes; halt_req outranks run there.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (run) next_state = ST_FE;
      ST_FE:   if (!mem_busy) next_state = ST_DC;
      ST_DC:   next_state = ST_EX;
      ST_EX:   next_state = (!SKIP_ME || is_mem_op) ? ST_ME : ST_WB;
      ST_ME:   if (!mem_busy) next_state = ST_WB;
      ST_WB: begin
        if (halt_req)  next_state = ST_HALT;
        else if (!run) next_state = ST_IDLE;
        else           next_state = ST_FE;
      end
      ST_HALT: if (!run) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // State, Moore outputs and retire counter. Outputs are decoded from
  // next_state so that they are flops yet still equal (state == X).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      s_fe        <= 1'b0;
      s_dc        <= 1'b0;
      s_ex        <= 1'b0;
      s_me        <= 1'b0;
      s_wb        <= 1'b0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      state  <= next_state;
      {s_fe, s_dc, s_ex, s_me, s_wb} <= strobe_vec(next_state);
      halted <= (next_state == ST_HALT);
      if (state == ST_WB) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

  // A stall cycle is one spent waiting on memory in a stage that needs it.
  assign stall_inc = mem_busy && ((state == ST_FE) || (state == ST_ME));

  sat_counter #(
    .W(STALL_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_count)
  );

endmodule

// File: tb/tb_stage_sequencer.sv
// ---------------------------------------------------------------------------
// tb_stage_sequencer
// Drives two sequencers from the same inputs: dut_a (defaults, ME skipped for
// non-memory ops) and dut_b (SKIP_ME=0, 4-bit counters so wrap and saturation
// are reachable). A stage-level reference model predicts both every cycle.
// ---------------------------------------------------------------------------
module tb_stage_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, run, mem_busy, is_mem_op, halt_req;

  logic        a_fe, a_dc, a_ex, a_me, a_wb, a_halted;
  logic [31:0] a_ic;
  logic [15:0] a_sc;
  logic        b_fe, b_dc, b_ex, b_me, b_wb, b_halted;
  logic [3:0]  b_ic;
  logic [3:0]  b_sc;

  stage_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .run(run), .mem_busy(mem_busy),
    .is_mem_op(is_mem_op), .halt_req(halt_req),
    .s_fe(a_fe), .s_dc(a_dc), .s_ex(a_ex), .s_me(a_me), .s_wb(a_wb),
    .halted(a_halted), .instr_count(a_ic), .stall_count(a_sc)
  );

  stage_sequencer #(.CNT_W(4), .STALL_W(4), .SKIP_ME(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .run(run), .mem_busy(mem_busy),
    .is_mem_op(is_mem_op), .halt_req(halt_req),
    .s_fe(b_fe), .s_dc(b_dc), .s_ex(b_ex), .s_me(b_me), .s_wb(b_wb),
    .halted(b_halted), .instr_count(b_ic), .stall_count(b_sc)
  );

  wire [5:0]  a_ctl   = {a_fe, a_dc, a_ex, a_me, a_wb, a_halted};
  wire [5:0]  b_ctl   = {b_fe, b_dc, b_ex, b_me, b_wb, b_halted};
  wire [67:0] act_all = {a_ctl, a_ic, a_sc, b_ctl, b_ic, b_sc};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: current stage as a letter, counters as plain integers.
  localparam byte S_I = "I";
  localparam byte S_F = "F";
  localparam byte S_D = "D";
  localparam byte S_E = "E";
  localparam byte S_M = "M";
  localparam byte S_W = "W";
  localparam byte S_H = "H";

  byte    m_st [2];
  longint m_ic [2];
  longint m_sc [2];

  function automatic longint ic_mod(input int i);
    return (i == 0) ? 64'h1_0000_0000 : 64'd16;
  endfunction

  function automatic longint sc_max(input int i);
    return (i == 0) ? 64'd65535 : 64'd15;
  endfunction

  function automatic bit skips_me(input int i);
    return (i == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = S_I;
      m_ic[i] = 0;
      m_sc[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      case (m_st[i])
        S_I: if (run) m_st[i] = S_F;
        S_F: begin
          if (mem_busy) begin
            if (m_sc[i] < sc_max(i)) m_sc[i] = m_sc[i] + 1;
          end else m_st[i] = S_D;
        end
        S_D: m_st[i] = S_E;
        S_E: m_st[i] = (!skips_me(i) || is_mem_op) ? S_M : S_W;
        S_M: begin
          if (mem_busy) begin
            if (m_sc[i] < sc_max(i)) m_sc[i] = m_sc[i] + 1;
          end else m_st[i] = S_W;
        end
        S_W: begin
          m_ic[i] = (m_ic[i] + 1) % ic_mod(i);
          if (halt_req)  m_st[i] = S_H;
          else if (!run) m_st[i] = S_I;
          else           m_st[i] = S_F;
        end
        S_H: if (!run) m_st[i] = S_I;
        default: m_st[i] = S_I;
      endcase
    end
  endtask

  function automatic logic [5:0] exp_ctl(input int i);
    return {m_st[i] == S_F, m_st[i] == S_D, m_st[i] == S_E,
            m_st[i] == S_M, m_st[i] == S_W, m_st[i] == S_H};
  endfunction

  function automatic logic [67:0] exp_all();
    return {exp_ctl(0), 32'(m_ic[0]), 16'(m_sc[0]),
            exp_ctl(1), 4'(m_ic[1]), 4'(m_sc[1])};
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    else       model_reset();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; mem_busy = 1'b0; is_mem_op = 1'b0; halt_req = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; run = 1'b1; mem_busy = 1'b1; is_mem_op = 1'b1; halt_req = 1'b1;
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (act_all !== 68'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_assert: got %h, want 0", act_all);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_tests++;
      if (act_all !== 68'd0) begin
        n_fail++;
        $display("[TB] FAIL reset_hold: got %h, want 0", act_all);
      end
    end
    do_reset();
  endtask

  task automatic test_sequence_basic();
    logic [5:0] pat_a [4];
    logic [5:0] pat_b [5];
    pat_a = '{6'b100000, 6'b010000, 6'b001000, 6'b000010};
    pat_b = '{6'b100000, 6'b010000, 6'b001000, 6'b000100, 6'b000010};
    do_reset();
    run = 1'b1;
    for (int c = 0; c < 13; c++) begin
      tick();
      n_tests++;
      if (act_all !== exp_all() || a_ctl !== pat_a[c % 4] || b_ctl !== pat_b[c % 5]) begin
        n_fail++;
        $display("[TB] FAIL basic_seq cycle %0d: got %h, want %h (a %b b %b)",
                 c, act_all, exp_all(), pat_a[c % 4], pat_b[c % 5]);
      end
    end
    n_tests++;
    if (a_ic !== 32'd3 || a_sc !== 16'd0 || b_ic !== 4'd2 || b_sc !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL basic_counts: got a_ic=%0d a_sc=%0d b_ic=%0d b_sc=%0d, want 3 0 2 0",
               a_ic, a_sc, b_ic, b_sc);
    end
  endtask

  task automatic test_mem_stall();
    int me_cycles;
    do_reset();
    run = 1'b1; is_mem_op = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    // busy is raised while still in EX, where it must not count
    mem_busy = 1'b1;
    me_cycles = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (a_me) me_cycles++;
      n_tests++;
      if (act_all !== exp_all()) begin
        n_fail++;
        $display("[TB] FAIL mem_stall cycle %0d: got %h, want %h", c, act_all, exp_all());
      end
    end
    mem_busy = 1'b0; is_mem_op = 1'b0;
    tick();
    n_tests++;
    if (me_cycles != 4 || a_wb !== 1'b1 || a_sc !== 16'd3 || b_sc !== 4'd3) begin
      n_fail++;
      $display("[TB] FAIL mem_stall_exit: got me_cycles=%0d wb=%b a_sc=%0d b_sc=%0d, want 4 1 3 3",
               me_cycles, a_wb, a_sc, b_sc);
    end
    tick();
    n_tests++;
    if (a_ic !== 32'd1 || a_fe !== 1'b1 || act_all !== exp_all()) begin
      n_fail++;
      $display("[TB] FAIL mem_stall_retire: got ic=%0d fe=%b all=%h, want 1 1 %h",
               a_ic, a_fe, act_all, exp_all());
    end
  endtask

  task automatic test_fe_stall();
    int fe_cycles;
    do_reset();
    run = 1'b1;
    tick();
    fe_cycles = a_fe ? 1 : 0;
    mem_busy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (a_fe) fe_cycles++;
    end
    mem_busy = 1'b0;
    tick();
    n_tests++;
    if (fe_cycles != 6 || a_dc !== 1'b1 || a_sc !== 16'd5 || act_all !== exp_all()) begin
      n_fail++;
      $display("[TB] FAIL fe_stall: got fe_cycles=%0d dc=%b sc=%0d all=%h, want 6 1 5 %h",
               fe_cycles, a_dc, a_sc, act_all, exp_all());
    end
  endtask

  task automatic test_halt();
    do_reset();
    run = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    halt_req = 1'b1;
    tick();
    n_tests++;
    if (a_ctl !== 6'b000001 || a_ic !== 32'd1 || act_all !== exp_all()) begin
      n_fail++;
      $display("[TB] FAIL halt_enter: got ctl=%b ic=%0d, want 000001 1", a_ctl, a_ic);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if (a_ctl !== 6'b000001 || act_all !== exp_all()) begin
        n_fail++;
        $display("[TB] FAIL halt_hold cycle %0d: got %h, want %h", c, act_all, exp_all());
      end
    end
    halt_req = 1'b0; run = 1'b0;
    tick();
    n_tests++;
    if (a_ctl !== 6'b000000 || act_all !== exp_all()) begin
      n_fail++;
      $display("[TB] FAIL halt_to_idle: got ctl=%b all=%h, want 000000 %h", a_ctl, act_all, exp_all());
    end
    run = 1'b1;
    tick();
    n_tests++;
    if (a_ctl !== 6'b100000 || act_all !== exp_all()) begin
      n_fail++;
      $display("[TB] FAIL halt_restart: got ctl=%b all=%h, want 100000 %h", a_ctl, act_all, exp_all());
    end
  endtask

  task automatic test_stall_saturate();
    do_reset();
    run = 1'b1;
    tick();
    mem_busy = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    mem_busy = 1'b0;
    n_tests++;
    if (b_sc !== 4'd15 || a_sc !== 16'd20 || act_all !== exp_all()) begin
      n_fail++;
      $display("[TB] FAIL stall_saturate: got b_sc=%0d a_sc=%0d, want 15 20", b_sc, a_sc);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    run = 1'b1;
    for (int c = 0; c < 7; c++) tick();
    n_tests++;
    if (a_ex !== 1'b1 || a_ic !== 32'd1 || act_all !== exp_all()) begin
      n_fail++;
      $display("[TB] FAIL async_pre: got ex=%b ic=%0d, want 1 1", a_ex, a_ic);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (act_all !== 68'd0) begin
      n_fail++;
      $display("[TB] FAIL async_assert: got %h, want 0", act_all);
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (a_ctl !== 6'b100000 || a_ic !== 32'd0 || act_all !== exp_all()) begin
      n_fail++;
      $display("[TB] FAIL async_release: got ctl=%b ic=%0d, want 100000 0", a_ctl, a_ic);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      run       = ($urandom_range(0, 9) != 0);
      mem_busy  = ($urandom_range(0, 2) == 0);
      is_mem_op = 1'($urandom);
      halt_req  = ($urandom_range(0, 15) == 0);
      tick();
      n_tests++;
      if (act_all !== exp_all()) begin
        n_fail++;
        $display("[TB] FAIL random cycle %0d: got %h, want %h", c, act_all, exp_all());
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence_basic();
    test_mem_stall();
    test_fe_stall();
    test_halt();
    test_stall_saturate();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
